// File: rtl/fifo_rd_stream_if.sv
// Read-port and output-stream bundle for fifo_rd_stream.
// master: the streaming consumer. slave: the FIFO plus the downstream sink.
interface fifo_rd_stream_if #(
  parameter int DATA_SIZE = 12
) ();
  logic                 rEmpty;
  logic [DATA_SIZE-1:0] rData;
  logic                 rinc;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    input  rEmpty, rData, out_ready,
    output rinc, out_data, out_valid, out_last
  );

  modport slave (
    output rEmpty, rData, out_ready,
    input  rinc, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO. Pops words under a credit limit,
// captures the registered rData one cycle later into a small buffer, and
// presents the buffer head as a valid/ready stream framed into packets.
//
// state | meaning
// IDLE  | no pops; waiting for en
// RUN   | pops allowed while credit is available
// DRAIN | en dropped; no new pops, in-flight and buffered words still go out
module fifo_rd_stream #(
  parameter int DATA_SIZE = 12,
  parameter int BUF_DEPTH = 2,
  parameter int PKT_LEN   = 16,
  parameter int CNT_W     = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               en,
  fifo_rd_stream_if.master   bus,
  output logic               busy,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ, occ_nxt;
  logic                 inflight;
  logic [PKT_W-1:0]     pkt_idx;
  logic [OCC_W:0]       pending;
  logic                 credit_ok;
  logic                 pop;
  logic                 xfer;
  logic                 out_valid_int;

  // Credit counts words already buffered plus the one whose rData is still
  // on its way, so a capture can never land in a full buffer.
  assign pending       = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign credit_ok     = pending < (OCC_W+1)'(BUF_DEPTH);
  assign bus.rinc      = (state == RUN) && !bus.rEmpty && credit_ok;
  assign pop           = bus.rinc && !bus.rEmpty;
  assign out_valid_int = (occ != '0);
  assign xfer          = out_valid_int && bus.out_ready;

  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_last  = out_valid_int && (pkt_idx == PKT_W'(PKT_LEN - 1));
  assign busy          = (state != IDLE);

  // Occupancy after this cycle's capture and transfer.
  always_comb begin
    occ_nxt = occ;
    if (inflight && !xfer) begin
      occ_nxt = occ + OCC_W'(1);
    end else if (!inflight && xfer) begin
      occ_nxt = occ - OCC_W'(1);
    end
  end

  // Next-state: DRAIN exits once nothing is buffered or in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if ((occ_nxt == '0) && !pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pop tracking and buffer bookkeeping; rData is captured the cycle after a pop.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= pop;
      occ      <= occ_nxt;
      if (inflight) begin
        mem[wr_ptr] <= bus.rData;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Packet position and delivered-word count; only rrst clears them.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pkt_idx  <= '0;
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + CNT_W'(1);
      if (pkt_idx == PKT_W'(PKT_LEN - 1)) begin
        pkt_idx <= '0;
      end else begin
        pkt_idx <= pkt_idx + PKT_W'(1);
      end
    end
  end

  // A capture into a full buffer would overwrite an undelivered word.
  a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
    !(inflight && (occ == OCC_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a behavioural FIFO feeds the read
// port, expected words are queued as they are loaded, and a negedge monitor
// pops and compares every transfer.
module tb_fifo_rd_stream;
  localparam int DW  = 12;
  localparam int PKT = 16;

  logic        rclk = 1'b0;
  logic        rrst = 1'b0;
  logic        en   = 1'b0;
  logic        busy;
  logic [15:0] word_cnt;

  fifo_rd_stream_if #(.DATA_SIZE(DW)) bus_if ();

  fifo_rd_stream #(
    .DATA_SIZE(DW), .BUF_DEPTH(2), .PKT_LEN(PKT), .CNT_W(16)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .en       (en),
    .bus      (bus_if),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO: registered read data, empty when indices meet.
  logic [DW-1:0] fmem [0:511];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          force_empty = 1'b0;
  logic [DW-1:0] rdata_r;

  assign bus_if.rEmpty = (rd_idx == wr_idx) || force_empty;
  assign bus_if.rData  = rdata_r;

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_idx  <= wr_idx;
      rdata_r <= '0;
    end else if (bus_if.rinc && !bus_if.rEmpty) begin
      rdata_r <= fmem[rd_idx];
      rd_idx  <= rd_idx + 1;
    end
  end

  // Independent occupancy / in-flight model.
  int occ_m = 0;
  int infl_m = 0;
  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ_m  <= 0;
      infl_m <= 0;
    end else begin
      infl_m <= (bus_if.rinc && !bus_if.rEmpty) ? 1 : 0;
      occ_m  <= occ_m + infl_m - (((occ_m != 0) && bus_if.out_ready) ? 1 : 0);
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_pkt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    fmem[wr_idx] = d;
    wr_idx++;
    exp_q.push_back('{data: d, last: (exp_pkt == PKT - 1)});
    exp_pkt = (exp_pkt + 1) % PKT;
  endtask

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic flush_reset();
    rrst = 1'b1;
    exp_q.delete();
    exp_pkt = 0;
    step();
    step();
    rrst = 1'b0;
  endtask

  // Monitor: compares each transfer against the scoreboard.
  int            mon_cnt = 0;
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d = '0;
  exp_t          e;
  initial begin
    forever begin
      @(negedge rclk);
      if (rrst) begin
        mon_cnt = 0;
        stall_v = 1'b0;
      end else begin
        chk("valid_vs_occ", bus_if.out_valid, (occ_m != 0));
        if (occ_m + infl_m >= 2) chk("credit_rinc", bus_if.rinc, 0);
        if (stall_v) chk("stall_hold", bus_if.out_data, stall_d);
        if (bus_if.out_valid && bus_if.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h, expected no transfer", bus_if.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus_if.out_data, e.data);
            chk("out_last", bus_if.out_last, e.last);
            chk("word_cnt_run", word_cnt, mon_cnt[15:0]);
          end
          mon_cnt++;
        end
        stall_v = bus_if.out_valid && !bus_if.out_ready;
        stall_d = bus_if.out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int rem;
    int n;
    bus_if.out_ready = 1'b0;
    #1 rrst = 1'b1;
    step();
    step();

    // Reset and idle: words present, en low.
    for (int i = 0; i < 5; i++) load(DW'(12'h5A0 + i));
    rrst = 1'b0;
    repeat (20) begin
      step();
      chk("idle_rinc", bus_if.rinc, 0);
      chk("idle_valid", bus_if.out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cnt", word_cnt, 0);
    end
    flush_reset();

    // Full-rate stream of 32 words.
    for (int i = 1; i <= 32; i++) load(DW'(i));
    en = 1'b1;
    bus_if.out_ready = 1'b1;
    step();
    chk("fill_rinc", bus_if.rinc, 1);
    chk("fill_busy", busy, 1);
    step();
    chk("fill_valid0", bus_if.out_valid, 0);
    step();
    chk("fill_valid1", bus_if.out_valid, 1);
    chk("fill_data", bus_if.out_data, 12'h001);
    wait_empty("stream", 200);
    step();
    chk("stream_cnt", word_cnt, 32);
    chk("stream_rinc_empty", bus_if.rinc, 0);

    // Backpressure: ready pattern 1,0,0,1.
    for (int i = 0; i < 40; i++) load(DW'(12'h100 + i));
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      bus_if.out_ready = ((n % 4) == 0) || ((n % 4) == 3);
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL backpressure: timeout, %0d words outstanding, expected 0", exp_q.size());
    end
    bus_if.out_ready = 1'b1;
    step();
    chk("bp_cnt", word_cnt, 72);

    // Empty gaps between single words.
    load(12'hABC);
    #1 chk("gap_rinc_a", bus_if.rinc, 1);
    step();
    chk("gap_lat_a0", bus_if.out_valid, 0);
    step();
    chk("gap_lat_a1", bus_if.out_valid, 1);
    chk("gap_data_a", bus_if.out_data, 12'hABC);
    step();
    force_empty = 1'b1;
    load(12'h123);
    #1 chk("gap_rinc_off0", bus_if.rinc, 0);
    step();
    chk("gap_rinc_off1", bus_if.rinc, 0);
    step();
    chk("gap_rinc_off2", bus_if.rinc, 0);
    step();
    force_empty = 1'b0;
    #1 chk("gap_rinc_b", bus_if.rinc, 1);
    step();
    chk("gap_lat_b0", bus_if.out_valid, 0);
    step();
    chk("gap_lat_b1", bus_if.out_valid, 1);
    chk("gap_data_b", bus_if.out_data, 12'h123);
    wait_empty("gap", 20);

    // Drain with a full buffer.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(DW'(12'h200 + i));
    n = 0;
    while (!(occ_m == 2 && infl_m == 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain_setup_occ", occ_m, 2);
    rem   = occ_m + infl_m;
    start = mon_cnt;
    en = 1'b0;
    bus_if.out_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (mon_cnt - start >= rem) break;
      chk("drain_rinc", bus_if.rinc, 0);
      chk("drain_busy", busy, 1);
    end
    chk("drain_delivered", mon_cnt - start, rem);
    chk("drain_busy_off", busy, 0);
    chk("drain_valid_off", bus_if.out_valid, 0);
    chk("drain_rinc_off", bus_if.rinc, 0);
    step();
    chk("drain_stay_idle", busy, 0);
    en = 1'b1;
    wait_empty("drain_rest", 50);
    step();
    chk("drain_cnt", word_cnt, 79);

    // Reset mid-packet.
    flush_reset();
    for (int i = 0; i < 20; i++) load(DW'(12'h300 + i));
    bus_if.out_ready = 1'b1;
    n = 0;
    while (mon_cnt < 7 && n < 50) begin
      step();
      n++;
    end
    bus_if.out_ready = 1'b0;
    chk("rst_pre_xfers", mon_cnt, 7);
    n = 0;
    while (!(occ_m == 2 && infl_m == 0) && n < 20) begin
      step();
      n++;
    end
    chk("rst_pre_occ", occ_m, 2);
    chk("rst_pre_valid", bus_if.out_valid, 1);
    rrst = 1'b1;
    #1;
    chk("rst_valid", bus_if.out_valid, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_rinc", bus_if.rinc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", bus_if.out_last, 0);
    chk("rst_data", bus_if.out_data, 0);
    exp_q.delete();
    exp_pkt = 0;
    step();
    step();
    rrst = 1'b0;
    for (int i = 0; i < 20; i++) load(DW'(12'h400 + i));
    bus_if.out_ready = 1'b1;
    wait_empty("post_reset", 100);
    step();
    chk("post_reset_cnt", word_cnt, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
